// File: rtl/sram_like_arbiter_if.sv
// One SRAM-like link: request fields flow master->slave, handshakes and read data flow back.
// The arbiter is the slave of each requester link and the master of the shared bus link.
interface sram_like_arbiter_if;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;

    modport master (
        output req, wr, size, addr, wdata,
        input  addr_ok, data_ok, rdata
    );

    modport slave (
        input  req, wr, size, addr, wdata,
        output addr_ok, data_ok, rdata
    );
endinterface

// File: rtl/sram_like_arbiter.sv
// Shares one SRAM-like master port between the inst and data requesters, one transaction at a time.
// A pipeline flush lets the bus transaction finish but hides its handshakes from the requester.
module sram_like_arbiter #(
    parameter bit ROUND_ROBIN = 1'b0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    sram_like_arbiter_if.slave         inst,
    sram_like_arbiter_if.slave         data,
    sram_like_arbiter_if.master        m,
    output logic                       busy,
    output logic                       owner
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;

    logic        owner_q;
    logic        last_grant;
    logic        drop;
    logic        m_wr_q;
    logic [1:0]  m_size_q;
    logic [31:0] m_addr_q;
    logic [31:0] m_wdata_q;

    logic        grant;
    logic        winner;
    logic        accept_ok;
    logic        resp_ok;

    // Winner selection: 1 = data, 0 = inst; flush blocks any new grant in IDLE.
    always_comb begin
        grant  = 1'b0;
        winner = 1'b0;
        if ((state == IDLE) && !flush && (inst.req || data.req)) begin
            grant = 1'b1;
            if (inst.req && data.req) begin
                winner = ROUND_ROBIN ? ~last_grant : 1'b1;
            end else begin
                winner = data.req;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (grant)     state_next = ADDR;
            ADDR:    if (m.addr_ok) state_next = DATA;
            DATA:    if (m.data_ok) state_next = IDLE;
            default:                state_next = IDLE;
        endcase
    end

    // Latched request fields are zeroed once the address phase is accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner_q    <= 1'b0;
            last_grant <= 1'b0;
            drop       <= 1'b0;
            m_wr_q     <= 1'b0;
            m_size_q   <= 2'd0;
            m_addr_q   <= 32'd0;
            m_wdata_q  <= 32'd0;
        end else begin
            if (grant) begin
                owner_q    <= winner;
                last_grant <= winner;
                drop       <= 1'b0;
                m_wr_q     <= winner ? data.wr    : inst.wr;
                m_size_q   <= winner ? data.size  : inst.size;
                m_addr_q   <= winner ? data.addr  : inst.addr;
                m_wdata_q  <= winner ? data.wdata : inst.wdata;
            end else if ((state == ADDR) && m.addr_ok) begin
                m_wr_q     <= 1'b0;
                m_size_q   <= 2'd0;
                m_addr_q   <= 32'd0;
                m_wdata_q  <= 32'd0;
            end
            if ((state != IDLE) && flush) begin
                drop <= 1'b1;
            end
        end
    end

    always_comb begin
        m.req   = (state == ADDR);
        m.wr    = m_wr_q;
        m.size  = m_size_q;
        m.addr  = m_addr_q;
        m.wdata = m_wdata_q;

        accept_ok = (state == ADDR) && m.addr_ok && !drop && !flush;
        resp_ok   = (state == DATA) && m.data_ok && !drop && !flush;

        inst.addr_ok = accept_ok && !owner_q;
        data.addr_ok = accept_ok &&  owner_q;
        inst.data_ok = resp_ok   && !owner_q;
        data.data_ok = resp_ok   &&  owner_q;
        inst.rdata   = (resp_ok && !owner_q) ? m.rdata : 32'd0;
        data.rdata   = (resp_ok &&  owner_q) ? m.rdata : 32'd0;

        busy  = (state != IDLE);
        owner = owner_q;
    end

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Directed bench: a fixed-priority instance covers single access, contention, flush and reset;
// a round-robin instance covers alternating grants.
module tb_sram_like_arbiter;

    logic clk = 1'b0;
    logic rst;
    logic flush;
    logic busy, owner, busy_rr, owner_rr;

    int   vectors     = 0;
    int   miscompares = 0;
    int   ni, nd;
    logic exp_own;

    always #5 clk = ~clk;

    sram_like_arbiter_if inst_if ();
    sram_like_arbiter_if data_if ();
    sram_like_arbiter_if m_if ();
    sram_like_arbiter_if inst_rr ();
    sram_like_arbiter_if data_rr ();
    sram_like_arbiter_if m_rr ();

    sram_like_arbiter #(.ROUND_ROBIN(1'b0)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .inst  (inst_if),
        .data  (data_if),
        .m     (m_if),
        .busy  (busy),
        .owner (owner)
    );

    sram_like_arbiter #(.ROUND_ROBIN(1'b1)) dut_rr (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .inst  (inst_rr),
        .data  (data_rr),
        .m     (m_rr),
        .busy  (busy_rr),
        .owner (owner_rr)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to the next falling edge and drive the selected bus-side responses.
    task automatic applyStimulus(input bit rr, input logic aok, input logic dok, input logic [31:0] rd);
        @(negedge clk);
        if (rr) begin
            m_rr.addr_ok = aok;
            m_rr.data_ok = dok;
            m_rr.rdata   = rd;
        end else begin
            m_if.addr_ok = aok;
            m_if.data_ok = dok;
            m_if.rdata   = rd;
        end
    endtask

    initial begin
        rst   = 1'b1;
        flush = 1'b0;
        inst_if.req = 0; inst_if.wr = 0; inst_if.size = 0; inst_if.addr = 0; inst_if.wdata = 0;
        data_if.req = 0; data_if.wr = 0; data_if.size = 0; data_if.addr = 0; data_if.wdata = 0;
        inst_rr.req = 0; inst_rr.wr = 0; inst_rr.size = 0; inst_rr.addr = 0; inst_rr.wdata = 0;
        data_rr.req = 0; data_rr.wr = 0; data_rr.size = 0; data_rr.addr = 0; data_rr.wdata = 0;
        m_if.addr_ok = 0; m_if.data_ok = 0; m_if.rdata = 0;
        m_rr.addr_ok = 0; m_rr.data_ok = 0; m_rr.rdata = 0;

        #2;
        checkOutput("rst_m_req",   m_if.req, 0);
        checkOutput("rst_m_addr",  m_if.addr, 0);
        checkOutput("rst_busy",    busy, 0);
        checkOutput("rst_owner",   owner, 0);
        checkOutput("rst_iaok",    inst_if.addr_ok, 0);
        checkOutput("rst_ddok",    data_if.data_ok, 0);
        checkOutput("rst_rr_busy", busy_rr, 0);
        applyStimulus(0, 0, 0, 0);
        rst = 1'b0;

        $display("[TB] single inst read");
        applyStimulus(0, 0, 0, 0);
        inst_if.req = 1; inst_if.wr = 0; inst_if.size = 2; inst_if.addr = 32'h1FC0_0000;
        #1;
        checkOutput("t1_req_idle",  m_if.req, 0);
        checkOutput("t1_no_early",  inst_if.addr_ok, 0);
        applyStimulus(0, 0, 0, 0); #1;
        checkOutput("t1_m_req",     m_if.req, 1);
        checkOutput("t1_m_addr",    m_if.addr, 32'h1FC0_0000);
        checkOutput("t1_m_wr",      m_if.wr, 0);
        checkOutput("t1_m_size",    m_if.size, 2);
        checkOutput("t1_busy",      busy, 1);
        checkOutput("t1_owner",     owner, 0);
        checkOutput("t1_iaok_wait", inst_if.addr_ok, 0);
        applyStimulus(0, 1, 0, 0); #1;
        checkOutput("t1_m_req_hs",  m_if.req, 1);
        checkOutput("t1_iaok",      inst_if.addr_ok, 1);
        checkOutput("t1_daok",      data_if.addr_ok, 0);
        applyStimulus(0, 0, 0, 0);
        inst_if.req = 0;
        #1;
        checkOutput("t1_m_req_off", m_if.req, 0);
        checkOutput("t1_m_addr_z",  m_if.addr, 0);
        checkOutput("t1_idok_wait", inst_if.data_ok, 0);
        checkOutput("t1_busy_data", busy, 1);
        applyStimulus(0, 0, 1, 32'h2408_0001); #1;
        checkOutput("t1_idok",      inst_if.data_ok, 1);
        checkOutput("t1_irdata",    inst_if.rdata, 32'h2408_0001);
        checkOutput("t1_ddok",      data_if.data_ok, 0);
        applyStimulus(0, 0, 0, 0); #1;
        checkOutput("t1_idle",      busy, 0);
        checkOutput("t1_irdata_z",  inst_if.rdata, 0);

        $display("[TB] fixed-priority contention");
        applyStimulus(0, 0, 0, 0);
        inst_if.req = 1; inst_if.wr = 0; inst_if.size = 2; inst_if.addr = 32'h0000_0100;
        data_if.req = 1; data_if.wr = 1; data_if.size = 2; data_if.addr = 32'h0000_1000;
        data_if.wdata = 32'hDEAD_BEEF;
        #1;
        checkOutput("t2_req_idle", m_if.req, 0);
        applyStimulus(0, 0, 0, 0); #1;
        checkOutput("t2_m_req",    m_if.req, 1);
        checkOutput("t2_owner",    owner, 1);
        checkOutput("t2_m_wr",     m_if.wr, 1);
        checkOutput("t2_m_wdata",  m_if.wdata, 32'hDEAD_BEEF);
        checkOutput("t2_m_addr",   m_if.addr, 32'h0000_1000);
        checkOutput("t2_iaok_a",   inst_if.addr_ok, 0);
        applyStimulus(0, 1, 0, 0); #1;
        checkOutput("t2_daok",     data_if.addr_ok, 1);
        checkOutput("t2_iaok_b",   inst_if.addr_ok, 0);
        applyStimulus(0, 0, 0, 0);
        data_if.req = 0;
        #1;
        checkOutput("t2_iaok_c",   inst_if.addr_ok, 0);
        checkOutput("t2_m_wdata_z", m_if.wdata, 0);
        applyStimulus(0, 0, 1, 32'h1234_5678); #1;
        checkOutput("t2_ddok",     data_if.data_ok, 1);
        checkOutput("t2_drdata",   data_if.rdata, 32'h1234_5678);
        checkOutput("t2_idok",     inst_if.data_ok, 0);
        checkOutput("t2_irdata_z", inst_if.rdata, 0);
        applyStimulus(0, 0, 0, 0); #1;
        checkOutput("t2_bubble",   busy, 0);
        checkOutput("t2_bubble_rq", m_if.req, 0);
        applyStimulus(0, 0, 0, 0); #1;
        checkOutput("t2_i_m_req",  m_if.req, 1);
        checkOutput("t2_i_owner",  owner, 0);
        checkOutput("t2_i_m_addr", m_if.addr, 32'h0000_0100);
        checkOutput("t2_i_m_wr",   m_if.wr, 0);
        applyStimulus(0, 1, 0, 0); #1;
        checkOutput("t2_i_aok",    inst_if.addr_ok, 1);
        applyStimulus(0, 0, 0, 0);
        inst_if.req = 0;
        #1;
        applyStimulus(0, 0, 1, 32'hCAFE_0001); #1;
        checkOutput("t2_i_dok",    inst_if.data_ok, 1);
        checkOutput("t2_i_rdata",  inst_if.rdata, 32'hCAFE_0001);
        applyStimulus(0, 0, 0, 0); #1;
        checkOutput("t2_idle",     busy, 0);

        $display("[TB] flush during data phase");
        applyStimulus(0, 0, 0, 0);
        inst_if.req = 1; inst_if.addr = 32'h0000_0200;
        #1;
        applyStimulus(0, 0, 0, 0); #1;
        checkOutput("t4_m_req",    m_if.req, 1);
        applyStimulus(0, 1, 0, 0); #1;
        checkOutput("t4_iaok",     inst_if.addr_ok, 1);
        applyStimulus(0, 0, 0, 0);
        inst_if.req = 0; flush = 1;
        #1;
        checkOutput("t4_busy",     busy, 1);
        checkOutput("t4_idok_fl",  inst_if.data_ok, 0);
        applyStimulus(0, 0, 1, 32'hAAAA_5555);
        flush = 0;
        #1;
        checkOutput("t4_idok_drop", inst_if.data_ok, 0);
        checkOutput("t4_irdata_z", inst_if.rdata, 0);
        applyStimulus(0, 0, 0, 0); #1;
        checkOutput("t4_idle",     busy, 0);
        applyStimulus(0, 0, 0, 0);
        inst_if.req = 1; inst_if.addr = 32'h0000_0204;
        #1;
        applyStimulus(0, 0, 0, 0); #1;
        checkOutput("t4_n_m_addr", m_if.addr, 32'h0000_0204);
        applyStimulus(0, 1, 0, 0); #1;
        checkOutput("t4_n_iaok",   inst_if.addr_ok, 1);
        applyStimulus(0, 0, 0, 0);
        inst_if.req = 0;
        #1;
        applyStimulus(0, 0, 1, 32'hBBBB_0001); #1;
        checkOutput("t4_n_idok",   inst_if.data_ok, 1);
        checkOutput("t4_n_irdata", inst_if.rdata, 32'hBBBB_0001);
        applyStimulus(0, 0, 0, 0); #1;
        checkOutput("t4_n_idle",   busy, 0);

        $display("[TB] flush in idle, then reset during address phase");
        applyStimulus(0, 0, 0, 0);
        flush = 1;
        data_if.req = 1; data_if.wr = 0; data_if.addr = 32'h0000_0300;
        #1;
        checkOutput("t5_m_req_fl", m_if.req, 0);
        applyStimulus(0, 0, 0, 0);
        flush = 0;
        #1;
        checkOutput("t5_no_grant", m_if.req, 0);
        checkOutput("t5_no_busy",  busy, 0);
        applyStimulus(0, 0, 0, 0); #1;
        checkOutput("t5_m_req",    m_if.req, 1);
        checkOutput("t5_owner",    owner, 1);
        checkOutput("t5_m_addr",   m_if.addr, 32'h0000_0300);
        applyStimulus(0, 1, 0, 0); #1;
        checkOutput("t6_daok_pre", data_if.addr_ok, 1);
        rst = 1;
        #1;
        checkOutput("t6_m_req",    m_if.req, 0);
        checkOutput("t6_busy",     busy, 0);
        checkOutput("t6_daok",     data_if.addr_ok, 0);
        checkOutput("t6_iaok",     inst_if.addr_ok, 0);
        checkOutput("t6_m_addr",   m_if.addr, 0);
        checkOutput("t6_owner",    owner, 0);
        data_if.req = 0;
        applyStimulus(0, 0, 0, 0);
        rst = 0;

        $display("[TB] round-robin contention");
        ni = 0;
        nd = 0;
        applyStimulus(1, 0, 0, 0);
        inst_rr.req = 1; inst_rr.wr = 0; inst_rr.size = 2; inst_rr.addr = 32'h0000_0400;
        data_rr.req = 1; data_rr.wr = 0; data_rr.size = 2; data_rr.addr = 32'h0000_0800;
        #1;
        for (int k = 0; k < 8; k++) begin
            exp_own = (k % 2 == 0);
            applyStimulus(1, 0, 0, 0); #1;
            checkOutput($sformatf("rr%0d_m_req", k), m_rr.req, 1);
            checkOutput($sformatf("rr%0d_owner", k), owner_rr, exp_own);
            checkOutput($sformatf("rr%0d_m_addr", k), m_rr.addr,
                        exp_own ? 32'h0000_0800 + 32'(4 * nd) : 32'h0000_0400 + 32'(4 * ni));
            applyStimulus(1, 1, 0, 0); #1;
            checkOutput($sformatf("rr%0d_daok", k), data_rr.addr_ok, exp_own);
            checkOutput($sformatf("rr%0d_iaok", k), inst_rr.addr_ok, !exp_own);
            applyStimulus(1, 0, 0, 0);
            if (exp_own) begin
                nd++;
                data_rr.addr = 32'h0000_0800 + 32'(4 * nd);
                if (nd == 4) data_rr.req = 0;
            end else begin
                ni++;
                inst_rr.addr = 32'h0000_0400 + 32'(4 * ni);
                if (ni == 4) inst_rr.req = 0;
            end
            #1;
            applyStimulus(1, 0, 1, 32'h5000_0000 + 32'(k)); #1;
            checkOutput($sformatf("rr%0d_ddok", k), data_rr.data_ok, exp_own);
            checkOutput($sformatf("rr%0d_idok", k), inst_rr.data_ok, !exp_own);
            applyStimulus(1, 0, 0, 0); #1;
            checkOutput($sformatf("rr%0d_idle", k), busy_rr, 0);
        end
        applyStimulus(1, 0, 0, 0); #1;
        checkOutput("rr_done_idle", busy_rr, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sram_like_arbiter.md
Name: sram_like_arbiter

Overview:
- Shares one SRAM-like master port (toward the cpu_axi bridge) between the instruction-side and data-side SRAM-like requesters produced by the core's SRAM-like interface.
- Exactly one transaction is in flight at a time.
- Grant policy is fixed-priority (data first) or round-robin.
- flush from the pipeline discards the response of an in-flight transaction without breaking bus protocol.

Parameters:
- ROUND_ROBIN, 0, 0 = data always beats inst; 1 = alternate grant when both request.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- flush  in  1  pipeline flush; discards the pending response (see Behaviour)
- inst_req  in  1  inst requester request; held until inst_addr_ok
- inst_wr  in  1  write flag
- inst_size  in  2  0:1B, 1:2B, 2:4B
- inst_addr  in  32  physical address
- inst_wdata  in  32  write data
- inst_addr_ok  out  1  address accepted
- inst_data_ok  out  1  read data valid / write done
- inst_rdata  out  32  read data
- data_req, data_wr, data_size, data_addr, data_wdata, data_addr_ok, data_data_ok, data_rdata: same as inst_*, for the data requester
- m_req  out  1  master request
- m_wr  out  1  master write flag
- m_size  out  2  master size
- m_addr  out  32  master address
- m_wdata  out  32  master write data
- m_addr_ok  in  1  master address handshake
- m_data_ok  in  1  master data handshake
- m_rdata  in  32  master read data
- busy  out  1  state != IDLE
- owner  out  1  0 = inst, 1 = data; valid while busy

Behaviour:
- Reset (async, rst=1): state=IDLE; owner=0; last_grant=0; drop=0; m_req=0; m_wr=0; m_size=0; m_addr=0; m_wdata=0. All *_addr_ok and *_data_ok are 0. *_rdata are 0 while their data_ok=0.
- State machine: IDLE -> ADDR -> DATA -> IDLE.
- IDLE:
  - If flush=1, stay in IDLE; no grant.
  - Otherwise, if any req=1, pick the winner, register its wr/size/addr/wdata into the m_* registers and set owner. Go to ADDR and clear drop.
  - Winner with ROUND_ROBIN=0: data if data_req, else inst.
  - Winner with ROUND_ROBIN=1 and both requesting: the side not equal to last_grant. last_grant updates at grant.
- ADDR:
  - m_req=1 with the registered fields, held stable until m_addr_ok.
  - The owner's *_addr_ok = m_addr_ok (combinational); the non-owner's addr_ok stays 0.
  - On m_addr_ok: next cycle m_req=0, m_addr=0, m_size=0, m_wr=0, m_wdata=0, state=DATA.
  - m_data_ok while in ADDR is ignored (protocol violation; no effect).
- DATA:
  - The owner's *_data_ok = m_data_ok & ~drop & ~flush. The owner's *_rdata = m_rdata in that cycle; otherwise 0.
  - On m_data_ok, go to IDLE.
- Latency:
  - Request is visible on m_req 1 cycle after req is first seen in IDLE.
  - Minimum 1 bubble cycle (IDLE) between consecutive transactions.
  - A requester's addr_ok never arrives in the cycle its req first rises.
- flush in ADDR or DATA:
  - The transaction runs to completion on the master side (no abort; m_req is held until m_addr_ok).
  - drop is set to 1 and stays set until the next grant.
  - The requester sees neither data_ok for that transaction. It sees addr_ok only if the handshake occurs in a cycle where flush=0 and drop=0; otherwise addr_ok is also suppressed.
- Requester contract:
  - A requester that deasserts req before addr_ok is a protocol violation; the arbiter still completes the latched transaction.
  - Requester inputs are don't-care outside IDLE sampling.
- Reset mid-transaction: immediately returns to IDLE with all outputs at their reset values. The master side is assumed reset together.
- Non-owner: addr_ok=0 and data_ok=0 for the entire transaction; its req stays pending and is arbitrated in the next IDLE.

Test Plan:
- Single inst read: inst_req=1, addr=0x1FC0_0000, size=2. m_addr_ok at cycle 3, m_data_ok with m_rdata=0x2408_0001 at cycle 5 -> m_req=1 in cycles 2-3 with m_addr=0x1FC0_0000, m_wr=0; inst_addr_ok=1 at cycle 3; inst_data_ok=1 and inst_rdata=0x2408_0001 at cycle 5; busy=0 at cycle 6.
- Contention, ROUND_ROBIN=0: inst and data both request continuously; data writes 0xDEADBEEF to 0x0000_1000 -> data granted first with m_wr=1, m_wdata=0xDEADBEEF; inst granted only after the data transaction completes and data_req drops; inst_addr_ok=0 throughout the data transaction.
- Contention, ROUND_ROBIN=1: both request 4 back-to-back transactions each -> grants alternate data, inst, data, inst... (first grant data, since last_grant resets to 0); owner toggles each transaction.
- Flush during DATA: inst read in flight; flush=1 for one cycle before m_data_ok -> m_data_ok consumed; inst_data_ok stays 0; state returns to IDLE; the next inst request completes normally with data_ok.
- Flush in IDLE with data_req=1 -> no grant that cycle (m_req stays 0); grant occurs the cycle after flush drops.
- Async reset asserted while in ADDR with m_req=1 -> m_req=0, busy=0 and all handshake outputs 0 before the next clk edge.
